// File: rtl/alu_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// alu_ctrl_pkg
// Shared definitions for the ALU command sequencer: unit-select codes taken
// from CMD_FUN[3:2], the sequencer FSM state encoding and the default
// response timeout (in WAIT cycles).
// ---------------------------------------------------------------------------
package alu_ctrl_pkg;

  localparam logic [1:0] UNIT_ARITH = 2'b00;
  localparam logic [1:0] UNIT_LOGIC = 2'b01;
  localparam logic [1:0] UNIT_CMP   = 2'b10;
  localparam logic [1:0] UNIT_SHIFT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  localparam int DEFAULT_TIMEOUT = 4;

endpackage

// File: rtl/alu_result_mux.sv
// ---------------------------------------------------------------------------
// alu_result_mux
// Combinational selector: picks the result and result-valid flag of the unit
// addressed by unit_sel_i and zero-extends narrow results to 2*WIDTH.
// Ports:
//   unit_sel_i            unit select (alu_ctrl_pkg UNIT_* codes)
//   arith_out_i           2*WIDTH arithmetic result
//   logic/cmp/shift_out_i WIDTH unit results
//   *_flag_i              per-unit result-valid flags
//   data_o                selected, zero-extended result
//   flag_o                selected unit's flag
// ---------------------------------------------------------------------------
module alu_result_mux
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [1:0]         unit_sel_i,
  input  logic [2*WIDTH-1:0] arith_out_i,
  input  logic [WIDTH-1:0]   logic_out_i,
  input  logic [WIDTH-1:0]   cmp_out_i,
  input  logic [WIDTH-1:0]   shift_out_i,
  input  logic               arith_flag_i,
  input  logic               logic_flag_i,
  input  logic               cmp_flag_i,
  input  logic               shift_flag_i,
  output logic [2*WIDTH-1:0] data_o,
  output logic               flag_o
);

  always_comb begin
    data_o = '0;
    flag_o = 1'b0;
    unique case (unit_sel_i)
      UNIT_ARITH: begin
        data_o = arith_out_i;
        flag_o = arith_flag_i;
      end
      UNIT_LOGIC: begin
        data_o = {{WIDTH{1'b0}}, logic_out_i};
        flag_o = logic_flag_i;
      end
      UNIT_CMP: begin
        data_o = {{WIDTH{1'b0}}, cmp_out_i};
        flag_o = cmp_flag_i;
      end
      UNIT_SHIFT: begin
        data_o = {{WIDTH{1'b0}}, shift_out_i};
        flag_o = shift_flag_i;
      end
      default: begin
        data_o = '0;
        flag_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// alu_op_sequencer
// Command-level controller for the ALU cluster (arith / logic / cmp / shift).
// Accepts one command over a valid/ready port, registers the operands, pulses
// the selected unit's enable for one cycle, waits for that unit's registered
// flag (bounded by TIMEOUT) and returns the result or a timeout error over a
// valid/ready response port.
// Ports:
//   clk_i, rst_i                clock, async active-high reset
//   cmd_valid_i/cmd_ready_o     command handshake
//   cmd_fun_i[3:2]/[1:0]        unit select / unit function
//   cmd_a_i, cmd_b_i            operands
//   alu_a_o, alu_b_o, alu_fun_o registered operands/function to all units
//   *_en_o                      one-cycle unit enables (one-hot or zero)
//   *_out_i, *_flag_i           unit results and result-valid flags
//   rsp_valid_o/rsp_ready_i     response handshake
//   rsp_data_o, rsp_err_o       result (zero-extended) and timeout error
// ---------------------------------------------------------------------------
module alu_op_sequencer
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  input  logic [3:0]         cmd_fun_i,
  input  logic [WIDTH-1:0]   cmd_a_i,
  input  logic [WIDTH-1:0]   cmd_b_i,
  output logic [WIDTH-1:0]   alu_a_o,
  output logic [WIDTH-1:0]   alu_b_o,
  output logic [1:0]         alu_fun_o,
  output logic               arith_en_o,
  output logic               logic_en_o,
  output logic               cmp_en_o,
  output logic               shift_en_o,
  input  logic [2*WIDTH-1:0] arith_out_i,
  input  logic [WIDTH-1:0]   logic_out_i,
  input  logic [WIDTH-1:0]   cmp_out_i,
  input  logic [WIDTH-1:0]   shift_out_i,
  input  logic               arith_flag_i,
  input  logic               logic_flag_i,
  input  logic               cmp_flag_i,
  input  logic               shift_flag_i,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic [2*WIDTH-1:0] rsp_data_o,
  output logic               rsp_err_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

  state_e               state_q, state_d;
  logic [1:0]           unit_q, unit_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [1:0]           fun_q, fun_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   rsp_data_q, rsp_data_d;
  logic                 rsp_err_q, rsp_err_d;

  logic [2*WIDTH-1:0]   sel_data;
  logic                 sel_flag;

  // Only the unit latched at accept time is ever observed, so stray flags
  // from the other units cannot complete the command.
  alu_result_mux #(
    .WIDTH (WIDTH)
  ) u_result_mux (
    .unit_sel_i   (unit_q),
    .arith_out_i  (arith_out_i),
    .logic_out_i  (logic_out_i),
    .cmp_out_i    (cmp_out_i),
    .shift_out_i  (shift_out_i),
    .arith_flag_i (arith_flag_i),
    .logic_flag_i (logic_flag_i),
    .cmp_flag_i   (cmp_flag_i),
    .shift_flag_i (shift_flag_i),
    .data_o       (sel_data),
    .flag_o       (sel_flag)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      unit_q     <= UNIT_ARITH;
      a_q        <= '0;
      b_q        <= '0;
      fun_q      <= '0;
      cnt_q      <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      unit_q     <= unit_d;
      a_q        <= a_d;
      b_q        <= b_d;
      fun_q      <= fun_d;
      cnt_q      <= cnt_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    unit_d     = unit_q;
    a_d        = a_q;
    b_d        = b_q;
    fun_d      = fun_q;
    cnt_d      = cnt_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          a_d     = cmd_a_i;
          b_d     = cmd_b_i;
          fun_d   = cmd_fun_i[1:0];
          unit_d  = cmd_fun_i[3:2];
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // The flag wins over the limit check, so a flag seen on the last
        // counted cycle still completes successfully.
        if (sel_flag) begin
          rsp_data_d = sel_data;
          rsp_err_d  = 1'b0;
          state_d    = ST_DONE;
        end else if (cnt_q == CNT_LIMIT) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          state_d    = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        if (rsp_ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Enables decode straight from the state register so they drop the
  // instant an asynchronous reset forces the state back to IDLE.
  always_comb begin
    arith_en_o = 1'b0;
    logic_en_o = 1'b0;
    cmp_en_o   = 1'b0;
    shift_en_o = 1'b0;
    if (state_q == ST_ISSUE) begin
      arith_en_o = (unit_q == UNIT_ARITH);
      logic_en_o = (unit_q == UNIT_LOGIC);
      cmp_en_o   = (unit_q == UNIT_CMP);
      shift_en_o = (unit_q == UNIT_SHIFT);
    end
  end

  assign cmd_ready_o = (state_q == ST_IDLE);
  assign rsp_valid_o = (state_q == ST_DONE);
  assign rsp_data_o  = rsp_data_q;
  assign rsp_err_o   = rsp_err_q;
  assign alu_a_o     = a_q;
  assign alu_b_o     = b_q;
  assign alu_fun_o   = fun_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_op_sequencer
// Directed bench for alu_op_sequencer (WIDTH=8, TIMEOUT=4). Simple unit
// models compute results from the registered operands and raise their flag a
// programmable number of cycles after their enable (0 = never); individual
// flags can also be forced high to emulate stray flags from idle units.
// ---------------------------------------------------------------------------
module tb_alu_op_sequencer;

  localparam int W  = 8;
  localparam int TO = 4;

  logic          clk;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [3:0]    cmd_fun;
  logic [W-1:0]  cmd_a, cmd_b;
  logic [W-1:0]  alu_a, alu_b;
  logic [1:0]    alu_fun;
  logic          arith_en, logic_en, cmp_en, shift_en;
  logic [2*W-1:0] arith_out;
  logic [W-1:0]  logic_out, cmp_out, shift_out;
  logic [3:0]    flg;
  logic          rsp_valid, rsp_ready;
  logic [2*W-1:0] rsp_data;
  logic          rsp_err;

  logic [3:0]    en;
  logic [7:0]    sr [4];
  int            lat_cfg;
  logic [3:0]    frc;

  int checks;
  int errors;

  alu_op_sequencer #(
    .WIDTH   (W),
    .TIMEOUT (TO)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (cmd_ready),
    .cmd_fun_i    (cmd_fun),
    .cmd_a_i      (cmd_a),
    .cmd_b_i      (cmd_b),
    .alu_a_o      (alu_a),
    .alu_b_o      (alu_b),
    .alu_fun_o    (alu_fun),
    .arith_en_o   (arith_en),
    .logic_en_o   (logic_en),
    .cmp_en_o     (cmp_en),
    .shift_en_o   (shift_en),
    .arith_out_i  (arith_out),
    .logic_out_i  (logic_out),
    .cmp_out_i    (cmp_out),
    .shift_out_i  (shift_out),
    .arith_flag_i (flg[0]),
    .logic_flag_i (flg[1]),
    .cmp_flag_i   (flg[2]),
    .shift_flag_i (flg[3]),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_data_o   (rsp_data),
    .rsp_err_o    (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign en = {shift_en, cmp_en, logic_en, arith_en};

  // Unit result models.
  always_comb begin
    arith_out = '0;
    logic_out = '0;
    cmp_out   = '0;
    shift_out = '0;
    case (alu_fun)
      2'b00: begin
        arith_out = {8'h00, alu_a} + {8'h00, alu_b};
        logic_out = alu_a & alu_b;
        cmp_out   = {7'b0, alu_a == alu_b};
        shift_out = alu_a << alu_b[2:0];
      end
      2'b01: begin
        arith_out = {8'h00, alu_a} - {8'h00, alu_b};
        logic_out = alu_a | alu_b;
        cmp_out   = {7'b0, alu_a < alu_b};
        shift_out = alu_a >> alu_b[2:0];
      end
      2'b10: begin
        arith_out = {8'h00, alu_a} * {8'h00, alu_b};
        logic_out = alu_a ^ alu_b;
        cmp_out   = {7'b0, alu_a > alu_b};
        shift_out = '0;
      end
      default: begin
        logic_out = ~alu_a;
      end
    endcase
  end

  // Per-unit enable history: sr[u][k] is the enable seen k+1 edges ago.
  always @(posedge clk) begin
    if (rst) begin
      for (int u = 0; u < 4; u++) sr[u] <= '0;
    end else begin
      for (int u = 0; u < 4; u++) sr[u] <= {sr[u][6:0], en[u]};
    end
  end

  always_comb begin
    for (int u = 0; u < 4; u++) begin
      flg[u] = frc[u];
      if (lat_cfg > 0 && lat_cfg <= 8) flg[u] = flg[u] | sr[u][lat_cfg-1];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Issue one command and wait for its response. Cycle numbering: the
  // accepting clock edge closes cycle 0; lat is the cycle RSP_VALID is seen.
  task automatic do_cmd(input logic [3:0] fun, input logic [7:0] a, input logic [7:0] b,
                        input bit hold,
                        output logic [15:0] data, output logic err, output int lat,
                        output int en_n, output logic [3:0] en_mask, output int en_cyc);
    int n;
    data    = '0;
    err     = 1'b0;
    lat     = -1;
    en_n    = 0;
    en_mask = '0;
    en_cyc  = -1;
    @(negedge clk);
    cmd_fun   = fun;
    cmd_a     = a;
    cmd_b     = b;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (|en) en_n++;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      if (|en) begin
        en_n++;
        en_mask = en_mask | en;
        en_cyc  = cyc;
      end
      if (rsp_valid) begin
        lat  = cyc;
        data = rsp_data;
        err  = rsp_err;
        break;
      end
    end
    if (!hold && lat > 0) begin
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
    end
  endtask

  typedef struct {
    logic [3:0]  fun;
    logic [7:0]  a;
    logic [7:0]  b;
    int          lat;
    logic [3:0]  stray;
    logic [15:0] exp_data;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[13];

  initial begin
    logic [15:0] d;
    logic        e;
    int          l, en_n, en_cyc, n;
    logic [3:0]  en_mask;
    logic [15:0] got [3];
    int          got_cyc [3];
    int          issued, nrsp;

    // fun, a, b, flag latency, stray flags, data, err, RSP_VALID cycle
    vecs[0]  = '{4'b0100, 8'hF0, 8'h3C, 1, 4'b0000, 16'h0030, 1'b0, 3};
    vecs[1]  = '{4'b0101, 8'hF0, 8'h3C, 1, 4'b0000, 16'h00FC, 1'b0, 3};
    vecs[2]  = '{4'b0110, 8'hF0, 8'h3C, 1, 4'b0000, 16'h00CC, 1'b0, 3};
    vecs[3]  = '{4'b0010, 8'h10, 8'h10, 1, 4'b0100, 16'h0100, 1'b0, 3};
    vecs[4]  = '{4'b0000, 8'hFF, 8'h01, 2, 4'b0100, 16'h0100, 1'b0, 4};
    vecs[5]  = '{4'b0001, 8'h05, 8'h07, 1, 4'b0000, 16'hFFFE, 1'b0, 3};
    vecs[6]  = '{4'b1010, 8'h80, 8'h7F, 1, 4'b0000, 16'h0001, 1'b0, 3};
    vecs[7]  = '{4'b1001, 8'h80, 8'h7F, 1, 4'b0000, 16'h0000, 1'b0, 3};
    vecs[8]  = '{4'b1100, 8'h81, 8'h03, 1, 4'b0000, 16'h0008, 1'b0, 3};
    vecs[9]  = '{4'b1101, 8'h81, 8'h01, 3, 4'b0000, 16'h0040, 1'b0, 5};
    vecs[10] = '{4'b1000, 8'h12, 8'h12, 0, 4'b1011, 16'h0000, 1'b1, 7};
    vecs[11] = '{4'b0100, 8'hFF, 8'h0F, 4, 4'b0000, 16'h000F, 1'b0, 6};
    vecs[12] = '{4'b1111, 8'hAA, 8'h01, 0, 4'b0000, 16'h0000, 1'b1, 7};

    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_fun   = '0;
    cmd_a     = '0;
    cmd_b     = '0;
    rsp_ready = 1'b0;
    lat_cfg   = 1;
    frc       = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rsp", {15'b0, rsp_valid, rsp_err, rsp_data}, 32'h0);
    chk("reset_alu", {14'b0, alu_fun, alu_a, alu_b}, 32'h0);
    chk("reset_en", {28'b0, en}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_cmd_ready", {31'b0, cmd_ready}, 32'h1);

    // Table-driven commands
    for (int i = 0; i < 13; i++) begin
      lat_cfg = vecs[i].lat;
      frc     = vecs[i].stray;
      do_cmd(vecs[i].fun, vecs[i].a, vecs[i].b, 1'b0, d, e, l, en_n, en_mask, en_cyc);
      chk($sformatf("v%0d_data", i), {16'b0, d}, {16'b0, vecs[i].exp_data});
      chk($sformatf("v%0d_err", i), {31'b0, e}, {31'b0, vecs[i].exp_err});
      chk($sformatf("v%0d_lat", i), l, vecs[i].exp_lat);
      chk($sformatf("v%0d_enable", i), {en_n[7:0], 4'b0, en_mask, en_cyc[15:0]},
          {8'd1, 4'b0, 4'b0001 << vecs[i].fun[3:2], 16'd1});
      frc = '0;
    end

    // Back-pressure: response held while a new command waits
    lat_cfg = 1;
    do_cmd(4'b0110, 8'h3C, 8'h0F, 1'b1, d, e, l, en_n, en_mask, en_cyc);
    chk("bp_first_data", {16'b0, d}, 32'h0033);
    cmd_fun   = 4'b0100;
    cmd_a     = 8'hF0;
    cmd_b     = 8'h3C;
    cmd_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("bp_hold%0d", k), {14'b0, cmd_ready, rsp_valid, rsp_data},
          {14'b0, 1'b0, 1'b1, 16'h0033});
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    chk("bp_idle", {30'b0, cmd_ready, rsp_valid}, 32'h2);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    chk("bp_next_issue", {28'b0, en}, 32'h2);
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bp_next_data", {15'b0, rsp_valid, rsp_data}, {15'b0, 1'b1, 16'h0030});
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;

    // Reset during WAIT
    lat_cfg = 0;
    @(negedge clk);
    cmd_fun   = 4'b1101;
    cmd_a     = 8'h81;
    cmd_b     = 8'h01;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_rsp", {15'b0, rsp_valid, rsp_err, rsp_data}, 32'h0);
    chk("midrst_alu_en", {10'b0, en, alu_fun, alu_a, alu_b}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_cmd_ready", {31'b0, cmd_ready}, 32'h1);
    lat_cfg = 1;
    do_cmd(4'b1101, 8'h81, 8'h01, 1'b0, d, e, l, en_n, en_mask, en_cyc);
    chk("midrst_after", {15'b0, e, d}, 32'h0040);
    chk("midrst_after_lat", l, 3);

    // Back-to-back with RSP_READY tied high
    rsp_ready = 1'b1;
    issued    = 0;
    nrsp      = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      if (rsp_valid && nrsp < 3) begin
        got[nrsp]     = rsp_data;
        got_cyc[nrsp] = cyc;
        nrsp++;
      end
      if (cmd_ready) begin
        if (issued < 3) begin
          cmd_valid = 1'b1;
          cmd_fun   = (issued == 0) ? 4'b0100 : (issued == 1) ? 4'b0101 : 4'b0110;
          cmd_a     = (issued == 0) ? 8'hAA : (issued == 1) ? 8'h11 : 8'hFF;
          cmd_b     = (issued == 0) ? 8'h0F : (issued == 1) ? 8'h22 : 8'h5A;
          issued++;
        end else begin
          cmd_valid = 1'b0;
        end
      end
    end
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    chk("b2b_count", nrsp, 3);
    if (nrsp == 3) begin
      chk("b2b_data0", {16'b0, got[0]}, 32'h000A);
      chk("b2b_data1", {16'b0, got[1]}, 32'h0033);
      chk("b2b_data2", {16'b0, got[2]}, 32'h00A5);
      chk("b2b_cyc0", got_cyc[0], 3);
      chk("b2b_cyc1", got_cyc[1], 7);
      chk("b2b_cyc2", got_cyc[2], 11);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
